serial_bit_driver: RTL and testbench

- Upstream stimulus stage for the enable-gated D flip-flop (ports clk, reset, en, d, q).
- Accepts a parallel word over a valid/ready handshake and serializes it MSB-first onto the flop's d input.
- Paces each bit over a programmable number of clocks and issues a one-cycle en strobe per bit, so the downstream flop captures exactly one bit per window.
- Replaces hand-written d/en sequences in benches and feeds the flop in system builds.

---
 rtl/serial_bit_driver.sv | 119 +++++++++++
 tb/tb_serial_bit_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_driver.sv
// Serializes a parallel word MSB-first onto d, with a one-cycle en strobe at the end
// of each DIV-clock bit window, followed by GAP idle clocks before the next load.
module serial_bit_driver #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d,
  output logic             en,
  output logic             done,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [BW-1:0]    bit_reg;
  logic [DW-1:0]    div_reg;
  logic [GW-1:0]    gap_reg;
  logic             d_reg;
  logic             en_reg;
  logic             done_reg;
  logic             busy_reg;
  logic [DW-1:0]    div_inc;

  assign div_inc = div_reg + 1'b1;

  // Outputs are registered to reflect the state being entered, so they line up
  // with the cycle numbering counted from the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shreg_reg <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      gap_reg   <= '0;
      d_reg     <= 1'b0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      en_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          d_reg    <= 1'b0;
          busy_reg <= 1'b0;
          if (load_valid) begin
            state_reg <= ST_SHIFT;
            shreg_reg <= load_data;
            bit_reg   <= '0;
            div_reg   <= '0;
            d_reg     <= load_data[WIDTH-1];
            en_reg    <= (DIV == 1);
            busy_reg  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_reg == DIV_LAST) begin
            shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
            div_reg   <= '0;
            if (bit_reg == BIT_LAST) begin
              done_reg <= 1'b1;
              d_reg    <= 1'b0;
              if (GAP > 0) begin
                state_reg <= ST_GAP;
                gap_reg   <= '0;
              end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              bit_reg <= bit_reg + 1'b1;
              d_reg   <= shreg_reg[WIDTH-2];
              en_reg  <= (DIV == 1);
            end
          end else begin
            div_reg <= div_inc;
            en_reg  <= (div_inc == DIV_LAST);
          end
        end
        ST_GAP: begin
          d_reg <= 1'b0;
          if (gap_reg == GAP_LAST) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          d_reg     <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = (state_reg == ST_IDLE);
  assign d          = d_reg;
  assign en         = en_reg;
  assign done       = done_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_serial_bit_driver.sv
// Bench for serial_bit_driver: a DIV=4/GAP=2 instance driving a model enable-gated
// flop, and a DIV=1/GAP=0 instance for the back-to-back corner.
module tb_serial_bit_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_a = 8'hFF, data_b = 8'hFF;
  logic       valid_a = 1'b1, valid_b = 1'b1;
  logic       ready_a, d_a, en_a, done_a, busy_a;
  logic       ready_b, d_b, en_b, done_b, busy_b;
  logic       q;

  int total = 0;
  int bad = 0;
  bit sel = 1'b0;
  bit sbq[$];
  bit exp_q = 1'b0;

  always #5 clk = ~clk;

  serial_bit_driver #(.WIDTH(8), .DIV(4), .GAP(2)) u_a (
    .clk(clk), .reset(reset), .load_data(data_a), .load_valid(valid_a),
    .load_ready(ready_a), .d(d_a), .en(en_a), .done(done_a), .busy(busy_a)
  );

  serial_bit_driver #(.WIDTH(8), .DIV(1), .GAP(0)) u_b (
    .clk(clk), .reset(reset), .load_data(data_b), .load_valid(valid_b),
    .load_ready(ready_b), .d(d_b), .en(en_b), .done(done_b), .busy(busy_b)
  );

  // Downstream enable-gated D flop fed by instance A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else if (en_a) q <= d_a;
  end

  wire d_s     = sel ? d_b     : d_a;
  wire en_s    = sel ? en_b    : en_a;
  wire done_s  = sel ? done_b  : done_a;
  wire busy_s  = sel ? busy_b  : busy_a;
  wire ready_s = sel ? ready_b : ready_a;

  typedef struct {
    logic [7:0] data;
    bit         s;
    int         pulses;
    int         done_n;
    int         ready_n;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Presents a word at a negedge and returns right after the accepting edge.
  task automatic start(input bit s, input logic [7:0] data);
    int waited = 0;
    @(negedge clk);
    sel = s;
    if (s) begin data_b = data; valid_b = 1'b1; end
    else begin data_a = data; valid_a = 1'b1; end
    while (!ready_s && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("start_ready", ready_s, 1);
    for (int i = 7; i >= 0; i--) sbq.push_back(data[i]);
    @(posedge clk);
  endtask

  // Checks cycles 1..ready_n after an accepting edge; ends at the negedge of ready_n.
  task automatic observe(input logic [7:0] data, input bit s, input int pulses,
                         input int done_n, input int ready_n, input bit keep,
                         input int chg_n, input logic [7:0] chg_data, input int stop_n);
    int dv = s ? 1 : 4;
    int seen = 0;
    bit exp_d;
    bit popped;
    for (int n = 1; n <= ready_n; n++) begin
      if (stop_n != 0 && n > stop_n) break;
      @(negedge clk);
      exp_d = (n < done_n) ? data[7 - (n - 1) / dv] : 1'b0;
      check($sformatf("en_c%0d", n), en_s, int'((n < done_n) && (n % dv == 0)));
      check($sformatf("d_c%0d", n), d_s, int'(exp_d));
      check($sformatf("done_c%0d", n), done_s, int'(n == done_n));
      check($sformatf("busy_c%0d", n), busy_s, int'(n < ready_n));
      check($sformatf("ready_c%0d", n), ready_s, int'(n == ready_n));
      if (!s) check($sformatf("q_c%0d", n), q, int'(exp_q));
      if (en_s) begin
        seen++;
        if (sbq.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          popped = sbq.pop_front();
          check("sb_d", d_s, int'(popped));
          if (!s) exp_q = popped;
        end
      end
      if (!keep && n == 1) begin
        if (s) valid_b = 1'b0; else valid_a = 1'b0;
      end
      if (n == chg_n) begin
        if (s) data_b = chg_data; else data_a = chg_data;
      end
    end
    if (stop_n == 0) begin
      check("pulses", seen, pulses);
      check("sb_empty", sbq.size(), 0);
    end
    $display("word %h on %s: pulses=%0d", data, s ? "B" : "A", seen);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 8, 33, 35};
    vecs[1] = '{8'h00, 1'b0, 8, 33, 35};
    vecs[2] = '{8'hFF, 1'b0, 8, 33, 35};
    vecs[3] = '{8'h5A, 1'b1, 8, 9, 9};

    // Reset hold with valid asserted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_d", d_a | d_b, 0);
      check("rst_en", en_a | en_b, 0);
      check("rst_busy", busy_a | busy_b, 0);
      check("rst_done", done_a | done_b, 0);
      check("rst_ready", ready_a & ready_b, 1);
    end
    $display("reset hold checked");
    reset = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;

    for (int v = 0; v < 4; v++) begin
      start(vecs[v].s, vecs[v].data);
      observe(vecs[v].data, vecs[v].s, vecs[v].pulses, vecs[v].done_n,
              vecs[v].ready_n, 1'b0, 0, 8'h00, 0);
    end

    // Valid held while busy; data changes in cycle 10, accepted at first IDLE edge.
    start(1'b0, 8'h3C);
    observe(8'h3C, 1'b0, 8, 33, 35, 1'b1, 10, 8'h81, 0);
    for (int i = 7; i >= 0; i--) sbq.push_back(1'(8'h81 >> i));
    @(posedge clk);
    observe(8'h81, 1'b0, 8, 33, 35, 1'b0, 0, 8'h00, 0);

    // Back-to-back with DIV=1, GAP=0: second word taken at the edge ending cycle 9.
    start(1'b1, 8'hF0);
    observe(8'hF0, 1'b1, 8, 9, 9, 1'b1, 5, 8'h0F, 0);
    for (int i = 7; i >= 0; i--) sbq.push_back(1'(8'h0F >> i));
    @(posedge clk);
    observe(8'h0F, 1'b1, 8, 9, 9, 1'b0, 0, 8'h00, 0);

    // Asynchronous reset mid-word, in cycle 13 while d=1 and busy=1.
    start(1'b0, 8'hD7);
    observe(8'hD7, 1'b0, 8, 33, 35, 1'b0, 0, 8'h00, 12);
    @(negedge clk);
    check("pre_rst_d", d_a, 1);
    check("pre_rst_busy", busy_a, 1);
    reset = 1'b1;
    #1;
    check("arst_d", d_a, 0);
    check("arst_en", en_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_ready", ready_a, 1);
    check("arst_q", q, 0);
    sbq.delete();
    exp_q = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_en", en_a, 0);
      check("post_rst_ready", ready_a, 1);
    end
    $display("mid-word reset checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
